// File: rtl/psychic5_sdram_rom_arbiter.sv
// Two-channel SDRAM read arbiter for the Psychic 5 main CPU and OBJ ROM ports.
// Optional word cache (addr bit 0 hits from the word latch): PSYCHIC5_SDRAM_WORDCACHE_EN.
module psychic5_sdram_rom_arbiter #(
  parameter logic [23:0] MAINCPU_BASE = 24'h000000,
  parameter logic [23:0] OBJROM_BASE  = 24'h010000
) (
  input  logic        i_EMU_MCLK,
  input  logic        i_EMU_INITRST,
  input  logic [16:0] i_MAINCPU_ADDR,
  input  logic        i_MAINCPU_RQ_n,
  output logic [7:0]  o_MAINCPU_DATA,
  input  logic [16:0] i_OBJROM_ADDR,
  input  logic        i_OBJROM_RQ_n,
  output logic [7:0]  o_OBJROM_DATA,
  output logic [23:0] o_SDRAM_ADDR,
  output logic        o_SDRAM_RD,
  input  logic [15:0] i_SDRAM_DATA,
  input  logic        i_SDRAM_ACK
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_READ = 1'b1;

`ifdef PSYCHIC5_SDRAM_WORDCACHE_EN
  localparam logic [16:0] TAG_MASK = 17'h1FFFE;
`else
  localparam logic [16:0] TAG_MASK = 17'h1FFFF;
`endif

  logic [0:0]  r_state;
  logic [23:0] r_sdram_addr;
  logic        r_sdram_rd;
  logic [16:0] r_req_addr;
  logic        r_grant_obj;
  logic        r_last_obj;
  logic [16:0] r_main_tag;
  logic        r_main_valid;
  logic [15:0] r_main_word;
  logic [7:0]  r_main_data;
  logic [16:0] r_obj_tag;
  logic        r_obj_valid;
  logic [15:0] r_obj_word;
  logic [7:0]  r_obj_data;

  logic        w_main_hit;
  logic        w_obj_hit;
  logic        w_main_pend;
  logic        w_obj_pend;
  logic        w_grant_obj;
  logic [16:0] w_req_addr;
  logic [23:0] w_sdram_addr;
  logic        w_ack;

  assign w_main_hit  = r_main_valid && (((i_MAINCPU_ADDR ^ r_main_tag) & TAG_MASK) == 17'h00000);
  assign w_obj_hit   = r_obj_valid  && (((i_OBJROM_ADDR  ^ r_obj_tag)  & TAG_MASK) == 17'h00000);
  assign w_main_pend = !i_MAINCPU_RQ_n && !w_main_hit;
  assign w_obj_pend  = !i_OBJROM_RQ_n  && !w_obj_hit;
  // On a tie the channel not served last wins.
  assign w_grant_obj  = w_obj_pend && (!w_main_pend || !r_last_obj);
  assign w_req_addr   = w_grant_obj ? i_OBJROM_ADDR : i_MAINCPU_ADDR;
  assign w_sdram_addr = (w_grant_obj ? OBJROM_BASE : MAINCPU_BASE) + {8'h00, w_req_addr[16:1]};
  assign w_ack        = (r_state == S_READ) && i_SDRAM_ACK;

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_INITRST) begin
      r_state      <= S_IDLE;
      r_sdram_addr <= 24'h000000;
      r_sdram_rd   <= 1'b0;
      r_req_addr   <= 17'h00000;
      r_grant_obj  <= 1'b0;
      r_last_obj   <= 1'b0;
      r_main_tag   <= 17'h00000;
      r_main_valid <= 1'b0;
      r_main_word  <= 16'h0000;
      r_obj_tag    <= 17'h00000;
      r_obj_valid  <= 1'b0;
      r_obj_word   <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_main_pend || w_obj_pend) begin
            r_state      <= S_READ;
            r_sdram_rd   <= 1'b1;
            r_sdram_addr <= w_sdram_addr;
            r_req_addr   <= w_req_addr;
            r_grant_obj  <= w_grant_obj;
          end
        end
        S_READ: begin
          if (i_SDRAM_ACK) begin
            r_state    <= S_IDLE;
            r_sdram_rd <= 1'b0;
            r_last_obj <= r_grant_obj;
            if (r_grant_obj) begin
              r_obj_word  <= i_SDRAM_DATA;
              r_obj_tag   <= r_req_addr;
              r_obj_valid <= 1'b1;
            end else begin
              r_main_word  <= i_SDRAM_DATA;
              r_main_tag   <= r_req_addr;
              r_main_valid <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_sdram_rd <= 1'b0;
        end
      endcase
    end
  end

  // Byte outputs: loaded from the returning word on ack, optionally re-selected on a word hit.
  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_INITRST) begin
      r_main_data <= 8'h00;
      r_obj_data  <= 8'h00;
    end else begin
      if (w_ack && !r_grant_obj) begin
        r_main_data <= r_req_addr[0] ? i_SDRAM_DATA[15:8] : i_SDRAM_DATA[7:0];
`ifdef PSYCHIC5_SDRAM_WORDCACHE_EN
      end else if (!i_MAINCPU_RQ_n && w_main_hit) begin
        r_main_data <= i_MAINCPU_ADDR[0] ? r_main_word[15:8] : r_main_word[7:0];
`endif
      end
      if (w_ack && r_grant_obj) begin
        r_obj_data <= r_req_addr[0] ? i_SDRAM_DATA[15:8] : i_SDRAM_DATA[7:0];
`ifdef PSYCHIC5_SDRAM_WORDCACHE_EN
      end else if (!i_OBJROM_RQ_n && w_obj_hit) begin
        r_obj_data <= i_OBJROM_ADDR[0] ? r_obj_word[15:8] : r_obj_word[7:0];
`endif
      end
    end
  end

  assign o_SDRAM_ADDR   = r_sdram_addr;
  assign o_SDRAM_RD     = r_sdram_rd;
  assign o_MAINCPU_DATA = r_main_data;
  assign o_OBJROM_DATA  = r_obj_data;

endmodule

// File: tb/tb_psychic5_sdram_rom_arbiter.sv
// Directed scoreboard bench for psychic5_sdram_rom_arbiter (SDRAM side modelled by tasks).
module tb_psychic5_sdram_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [16:0] main_addr = 17'h00000;
  logic        main_rq_n = 1'b1;
  logic [7:0]  main_data;
  logic [16:0] obj_addr = 17'h00000;
  logic        obj_rq_n = 1'b1;
  logic [7:0]  obj_data;
  logic [23:0] sd_addr;
  logic        sd_rd;
  logic [15:0] sd_data = 16'h0000;
  logic        sd_ack = 1'b0;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [23:0] exp_q[$];

  psychic5_sdram_rom_arbiter dut (
    .i_EMU_MCLK     (clk),
    .i_EMU_INITRST  (rst),
    .i_MAINCPU_ADDR (main_addr),
    .i_MAINCPU_RQ_n (main_rq_n),
    .o_MAINCPU_DATA (main_data),
    .i_OBJROM_ADDR  (obj_addr),
    .i_OBJROM_RQ_n  (obj_rq_n),
    .o_OBJROM_DATA  (obj_data),
    .o_SDRAM_ADDR   (sd_addr),
    .o_SDRAM_RD     (sd_rd),
    .i_SDRAM_DATA   (sd_data),
    .i_SDRAM_ACK    (sd_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a read request and compare its address with the scoreboard head.
  task automatic wait_rd(input string tag, output int lat);
    logic        found;
    logic [23:0] exp;
    found = 1'b0;
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      lat++;
      if (sd_rd === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk({tag, "_rd_seen"}, {23'h0, found}, 24'h000001);
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    else exp = 24'hFFFFFF;
    chk({tag, "_addr"}, sd_addr, exp);
  endtask

  task automatic do_ack(input logic [15:0] d, input int delay);
    repeat (delay) tick();
    sd_ack  = 1'b1;
    sd_data = d;
    tick();
    sd_ack  = 1'b0;
    sd_data = 16'h0000;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    main_rq_n = 1'b1;
    obj_rq_n  = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    int          lat;
    int          rd_cycles;
    logic [16:0] m_a;
    logic [16:0] o_a;
    logic [15:0] w;

    // Reset then idle
    tick();
    reset_dut();
    rd_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sd_rd !== 1'b0) rd_cycles++;
    end
    chk("idle_rd_cycles", rd_cycles[23:0], 24'h000000);
    chk("idle_main_data", {16'h0, main_data}, 24'h000000);
    chk("idle_obj_data", {16'h0, obj_data}, 24'h000000);

    // Single MAIN miss, odd byte
    main_addr = 17'h00005;
    main_rq_n = 1'b0;
    exp_q.push_back(24'h000002);
    wait_rd("main1", lat);
    chk("main1_rd_latency", lat[23:0], 24'h000001);
    do_ack(16'hBEEF, 1);
    chk("main1_data", {16'h0, main_data}, 24'h0000BE);
    chk("main1_rd_clear", {23'h0, sd_rd}, 24'h000000);

    // Same word, even byte
    main_addr = 17'h00004;
`ifdef PSYCHIC5_SDRAM_WORDCACHE_EN
    tick();
    chk("hit_data", {16'h0, main_data}, 24'h0000EF);
    rd_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      if (sd_rd !== 1'b0) rd_cycles++;
      tick();
    end
    chk("hit_no_rd", rd_cycles[23:0], 24'h000000);
`else
    exp_q.push_back(24'h000002);
    wait_rd("refetch", lat);
    do_ack(16'hBEEF, 0);
    chk("refetch_data", {16'h0, main_data}, 24'h0000EF);
`endif

    // Simultaneous requests after reset: OBJ first
    reset_dut();
    tick();
    obj_addr  = 17'h00010;
    main_addr = 17'h00100;
    obj_rq_n  = 1'b0;
    main_rq_n = 1'b0;
    exp_q.push_back(24'h010008);
    exp_q.push_back(24'h000080);
    wait_rd("tie_obj", lat);
    do_ack(16'h1234, 0);
    chk("tie_obj_data", {16'h0, obj_data}, 24'h000034);
    wait_rd("tie_main", lat);
    do_ack(16'h5678, 0);
    chk("tie_main_data", {16'h0, main_data}, 24'h000078);

    // Both continuously pending: strict OBJ/MAIN alternation
    m_a = 17'h00301;
    o_a = 17'h00400;
    main_addr = m_a;
    obj_addr  = o_a;
    for (int k = 0; k < 8; k++) begin
      if ((k % 2) == 0) begin
        exp_q.push_back(24'h010000 + {8'h00, o_a[16:1]});
        w = {8'hA0 + k[7:0], 8'h50 + k[7:0]};
        wait_rd("alt_obj", lat);
        do_ack(w, k % 3);
        chk("alt_obj_data", {16'h0, obj_data}, {16'h0, w[7:0]});
        o_a = o_a + 17'h00006;
        obj_addr = o_a;
      end else begin
        exp_q.push_back(24'h000000 + {8'h00, m_a[16:1]});
        w = {8'hC0 + k[7:0], 8'h30 + k[7:0]};
        wait_rd("alt_main", lat);
        do_ack(w, k % 3);
        chk("alt_main_data", {16'h0, main_data}, {16'h0, w[15:8]});
        m_a = m_a + 17'h00006;
        main_addr = m_a;
      end
    end

    // Address change during READ
    reset_dut();
    main_addr = 17'h00020;
    main_rq_n = 1'b0;
    exp_q.push_back(24'h000010);
    exp_q.push_back(24'h000020);
    wait_rd("chg_first", lat);
    main_addr = 17'h00040;
    tick();
    chk("chg_addr_stable", sd_addr, 24'h000010);
    do_ack(16'hAAAA, 1);
    wait_rd("chg_second", lat);
    do_ack(16'hC3D4, 0);
    chk("chg_final_data", {16'h0, main_data}, 24'h0000D4);

    // Reset mid-READ, late ack ignored, valid cleared
    main_addr = 17'h00050;
    exp_q.push_back(24'h000028);
    wait_rd("mid_rd", lat);
    rst = 1'b1;
    main_rq_n = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_rd", {23'h0, sd_rd}, 24'h000000);
    chk("rst_sd_addr", sd_addr, 24'h000000);
    chk("rst_main_data", {16'h0, main_data}, 24'h000000);
    do_ack(16'hFFFF, 0);
    tick();
    chk("late_ack_rd", {23'h0, sd_rd}, 24'h000000);
    chk("late_ack_data", {16'h0, main_data}, 24'h000000);
    chk("late_ack_obj_data", {16'h0, obj_data}, 24'h000000);
    main_addr = 17'h00040;
    main_rq_n = 1'b0;
    exp_q.push_back(24'h000020);
    wait_rd("post_rst", lat);
    do_ack(16'h1122, 0);
    chk("post_rst_data", {16'h0, main_data}, 24'h000022);
    chk("queue_empty", exp_q.size(), 24'h000000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/psychic5_sdram_rom_arbiter.md
# psychic5_sdram_rom_arbiter

Two-channel SDRAM read arbiter directly downstream of the Psychic 5 core's external ROM request ports. It accepts the main CPU program ROM and sprite (OBJ) ROM fetch requests and serialises them into single-word reads on the platform SDRAM controller. It also returns the selected byte to each channel and holds it stable between requests. The core treats the data as combinational ROM contents, so each channel's byte must stay valid until that channel's address changes.

## Interface
Parameters:
- MAINCPU_BASE, 24'h000000, SDRAM word address of main CPU ROM byte 0
- OBJROM_BASE, 24'h010000, SDRAM word address of OBJ ROM byte 0

Ports:
- i_EMU_MCLK  in  1  master clock; all logic on rising edge
- i_EMU_INITRST  in  1  synchronous, active-high reset
- i_MAINCPU_ADDR  in  17  main CPU ROM byte address
- i_MAINCPU_RQ_n  in  1  main CPU request, active low (level)
- o_MAINCPU_DATA  out  8  main CPU ROM byte
- i_OBJROM_ADDR  in  17  OBJ ROM byte address
- i_OBJROM_RQ_n  in  1  OBJ request, active low (level)
- o_OBJROM_DATA  out  8  OBJ ROM byte
- o_SDRAM_ADDR  out  24  SDRAM word address
- o_SDRAM_RD  out  1  read request, held until ack
- i_SDRAM_DATA  in  16  read word; even byte is in [7:0], odd byte is in [15:8]
- i_SDRAM_ACK  in  1  one-cycle pulse; i_SDRAM_DATA is valid in the same cycle

## Operation
- Each channel keeps a tag register, a valid bit and a 16-bit word latch.
- A channel is pending when RQ_n=0 AND (valid=0 OR the address misses the tag). The tag compare is combinational and is evaluated every cycle.
- RQ_n=1 suppresses new fetches. The outputs hold their last value.
- FSM has two states: IDLE and READ.
- IDLE -> READ when either channel is pending.
  - The winner's address is latched.
  - o_SDRAM_ADDR = BASE + addr[16:1], computed as a 24-bit unsigned add that wraps modulo 2^24.
  - o_SDRAM_RD is set to 1.
- Arbitration when both channels are pending: grant the channel not served last.
  - The "last served" register resets to MAIN, so OBJ wins the first tie.
  - When only one channel is pending, it wins.
- READ -> IDLE on i_SDRAM_ACK.
  - o_SDRAM_RD is cleared.
  - The word latch and tag are loaded, and valid is set to 1.
  - The "last served" register is updated.
- Data outputs:
  - DATA = addr[0] ? word[15:8] : word[7:0].
  - The output is registered, using the latched tag's byte select and the current addr[0] (see Configuration).
- Address change during READ:
  - The in-flight read completes for the latched address.
  - The mismatch is re-detected in IDLE and triggers a new read.
- i_SDRAM_ACK in IDLE is ignored.
- Reset (any cycle, including mid-READ):
  - State = IDLE, o_SDRAM_RD=0, o_SDRAM_ADDR=0.
  - Both valid bits = 0, both DATA outputs = 8'h00, last served = MAIN.
  - A late ack after reset is ignored.

## Timing
- Pending detected in cycle N: o_SDRAM_RD=1 and o_SDRAM_ADDR valid from cycle N+1.
- o_SDRAM_ADDR is stable for the whole READ state.
- Ack in cycle M: DATA updated and o_SDRAM_RD=0 at M+1. The earliest next request is M+2 (one IDLE cycle minimum).
- Miss latency = (M−N)+1 cycles. With ack in the first READ cycle, the minimum is 2 cycles.
- Hit (Configuration enabled): DATA reflects the new addr[0] one cycle after the address change, with no SDRAM access.
- Both channels pending continuously: the channels alternate, so each is serviced within two SDRAM transactions.

## Configuration
- PSYCHIC5_SDRAM_WORDCACHE_EN defined:
  - The tag is addr[16:1].
  - An address differing only in bit 0 is a hit and is served from the word latch. DATA updates after 1 cycle with no SDRAM read.
- PSYCHIC5_SDRAM_WORDCACHE_EN undefined:
  - The tag is addr[16:0].
  - Every address change while RQ_n=0 issues a new SDRAM read.
  - DATA is taken from the byte selected at fetch time.

## Test plan
- Reset then idle, RQ_n=1 on both channels, 20 cycles -> o_SDRAM_RD=0, both DATA=8'h00.
- MAIN addr 17'h00005, RQ_n=0, ack with 16'hBEEF two cycles later -> o_SDRAM_ADDR=24'h000002, o_MAINCPU_DATA=8'hBE; with the cache enabled, changing addr to 17'h00004 -> DATA=8'hEF next cycle with no o_SDRAM_RD.
- Both channels requesting in the same cycle (OBJ addr 17'h00010, MAIN addr 17'h00100) after reset -> first o_SDRAM_ADDR=24'h010008 (OBJ), second 24'h000080 (MAIN).
- Both channels change address on every ack for 8 transactions -> the grants alternate OBJ/MAIN strictly.
- MAIN address changes from 17'h00020 to 17'h00040 during READ -> the first read completes at 24'h000010, then a second read at 24'h000020; DATA ends with the byte from the second word.
- Reset asserted mid-READ, then ack pulsed -> o_SDRAM_RD=0, valid bits cleared, DATA=8'h00, the ack is ignored, and a fresh read is issued once RQ_n=0.
